// File: rtl/qa_drv_hc_tx_buffer.sv
// qa_drv_hc_tx_buffer: show-ahead TX FIFO with registered tx_rdy and sticky protocol-error flags.
// Define QA_DRV_HC_TX_BUF_STATS_EN to add the stat_enq_cnt and stat_hwm ports.
module qa_drv_hc_tx_buffer #(
  parameter int CCI_DATA_WIDTH = 512,
  parameter int DEPTH = 16,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CCI_DATA_WIDTH-1:0] tx_data,
  input  logic                      tx_enable,
  output logic                      tx_rdy,
  input  logic                      flush,
  output logic [CCI_DATA_WIDTH-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_deq,
  output logic [CNT_WIDTH-1:0]      count,
  output logic                      err_overflow,
  output logic                      err_underflow
`ifdef QA_DRV_HC_TX_BUF_STATS_EN
  ,
  output logic [31:0]               stat_enq_cnt,
  output logic [CNT_WIDTH-1:0]      stat_hwm
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);
  logic [CCI_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic r_tx_rdy, r_out_valid, r_err_ovf, r_err_udf;
  logic w_enq, w_deq;
  logic [CNT_WIDTH-1:0] w_count_next;
  assign w_enq = tx_enable && r_tx_rdy && !flush;
  assign w_deq = out_deq && r_out_valid && !flush;
  assign w_count_next = flush ? '0 : r_count + CNT_WIDTH'(w_enq) - CNT_WIDTH'(w_deq);
  assign tx_rdy = r_tx_rdy;
  assign out_valid = r_out_valid;
  assign out_data = r_mem[r_rptr];
  assign count = r_count;
  assign err_overflow = r_err_ovf;
  assign err_underflow = r_err_udf;
  // storage write; contents need no reset since out_valid gates them
  always_ff @(posedge clk)
    if (w_enq && !reset) r_mem[r_wptr] <= tx_data;
  // pointers, occupancy, flow control and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
      r_tx_rdy <= 1'b1;
      r_out_valid <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      r_wptr <= flush ? '0 : r_wptr + PTR_W'(w_enq);
      r_rptr <= flush ? '0 : r_rptr + PTR_W'(w_deq);
      r_count <= w_count_next;
      r_tx_rdy <= w_count_next < FULL;
      r_out_valid <= w_count_next != '0;
      if (tx_enable && !r_tx_rdy && !flush) r_err_ovf <= 1'b1;
      if (out_deq && !r_out_valid && !flush) r_err_udf <= 1'b1;
    end
  end
`ifdef QA_DRV_HC_TX_BUF_STATS_EN
  logic [31:0] r_enq_cnt;
  logic [CNT_WIDTH-1:0] r_hwm;
  assign stat_enq_cnt = r_enq_cnt;
  assign stat_hwm = r_hwm;
  // enqueue total and high-water mark survive flush, clear only on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enq_cnt <= '0;
      r_hwm <= '0;
    end else begin
      r_enq_cnt <= r_enq_cnt + 32'(w_enq);
      r_hwm <= (w_count_next > r_hwm) ? w_count_next : r_hwm;
    end
  end
`endif
endmodule

// File: tb/tb_qa_drv_hc_tx_buffer.sv
// tb_qa_drv_hc_tx_buffer: self-checking bench with reference queue model and vector table.
module tb_qa_drv_hc_tx_buffer;
  localparam int W = 512;
  localparam int D = 16;
  localparam int CW = $clog2(D + 1);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] tx_data = '0;
  logic tx_enable = 1'b0, flush = 1'b0, out_deq = 1'b0;
  logic tx_rdy, out_valid, err_overflow, err_underflow;
  logic [W-1:0] out_data;
  logic [CW-1:0] count;
`ifdef QA_DRV_HC_TX_BUF_STATS_EN
  logic [31:0] stat_enq_cnt;
  logic [CW-1:0] stat_hwm;
`endif
  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;
  typedef struct {
    logic en;
    logic [63:0] data;
    logic deq;
    logic fl;
    int exp_count;
    logic exp_valid;
    logic [63:0] exp_head;
    logic exp_udf;
  } vec_t;
  vec_t vt[6];
  qa_drv_hc_tx_buffer #(.CCI_DATA_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_enable(tx_enable), .tx_rdy(tx_rdy),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_deq(out_deq),
    .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow)
`ifdef QA_DRV_HC_TX_BUF_STATS_EN
    , .stat_enq_cnt(stat_enq_cnt), .stat_hwm(stat_hwm)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tx_enable = 1'b0;
    out_deq = 1'b0;
    flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask
  task automatic step(input logic en, input logic [63:0] d, input logic deq, input logic fl);
    logic [63:0] e;
    chk("tx_rdy", 64'(tx_rdy), 64'(sb.size() < D));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    tx_enable = en;
    tx_data = '0;
    tx_data[63:0] = d;
    out_deq = deq;
    flush = fl;
    if (fl) sb.delete();
    else begin
      if (en && sb.size() == D) m_ovf = 1'b1;
      if (deq && sb.size() == 0) m_udf = 1'b1;
      if (deq && sb.size() != 0) begin
        e = sb.pop_front();
        chk("head_data", out_data[63:0], e);
      end
      if (en && sb.size() < D) sb.push_back(d);
    end
    @(posedge clk);
    #1;
    tx_enable = 1'b0;
    out_deq = 1'b0;
    flush = 1'b0;
    chk("count", 64'(count), 64'(sb.size()));
    chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
    chk("err_underflow", 64'(err_underflow), 64'(m_udf));
    if (sb.size() != 0) chk("out_data", out_data[63:0], sb[0]);
  endtask
  initial begin
    vt[0] = '{1'b1, 64'hA1, 1'b0, 1'b0, 1, 1'b1, 64'hA1, 1'b0};
    vt[1] = '{1'b1, 64'hA2, 1'b1, 1'b0, 1, 1'b1, 64'hA2, 1'b0};
    vt[2] = '{1'b0, 64'h00, 1'b1, 1'b0, 0, 1'b0, 64'h00, 1'b0};
    vt[3] = '{1'b1, 64'hAB, 1'b1, 1'b0, 1, 1'b1, 64'hAB, 1'b1};
    vt[4] = '{1'b1, 64'hC4, 1'b0, 1'b0, 2, 1'b1, 64'hAB, 1'b1};
    vt[5] = '{1'b1, 64'hC5, 1'b1, 1'b1, 0, 1'b0, 64'h00, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 1; i <= D; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_rdy", 64'(tx_rdy), 64'd0);
    chk("full_head", out_data[63:0], 64'h1);
    for (int i = 0; i < D; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("drained_valid", 64'(out_valid), 64'd0);
    do_reset();
    step(1'b1, 64'h100, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 64'h200 + 64'(i), 1'b1, 1'b0);
      if (count != 1 || !tx_rdy) chk("stream_level", {count != 1, tx_rdy}, 64'h1);
    end
    chk("stream_head", out_data[63:0], 64'h200 + 64'd99);
    do_reset();
    for (int i = 1; i <= D; i++) step(1'b1, 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'hDEAD, 1'b0, 1'b0);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_head", out_data[63:0], 64'h1);
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_errs", {err_overflow, err_underflow}, 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 64'h50 + 64'(i), 1'b0, 1'b0);
    step(1'b1, 64'h77, 1'b1, 1'b1);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_rdy", 64'(tx_rdy), 64'd1);
    chk("flush_errs", {err_overflow, err_underflow}, 64'd0);
`ifdef QA_DRV_HC_TX_BUF_STATS_EN
    chk("stat_enq_cnt", 64'(stat_enq_cnt), 64'd5);
    chk("stat_hwm", 64'(stat_hwm), 64'd5);
`endif
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vt[i].en, vt[i].data, vt[i].deq, vt[i].fl);
      chk($sformatf("vec%0d_count", i), 64'(count), 64'(vt[i].exp_count));
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].exp_valid));
      chk($sformatf("vec%0d_udf", i), 64'(err_underflow), 64'(vt[i].exp_udf));
      if (vt[i].exp_valid) chk($sformatf("vec%0d_head", i), out_data[63:0], vt[i].exp_head);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
